// File: rtl/kcuart_pkg.sv
// Shared constants for the compact UART.
// Provides the RX buffer address width and the character-timeout sizing
// (characters x 10 bits x 16 oversample).
package kcuart_pkg;

  localparam int unsigned KCUART_RXBUF_ADDR_W  = 4;
  localparam int unsigned KCUART_TMO_CHARS     = 4;
  localparam int unsigned KCUART_BITS_PER_CHAR = 10;
  localparam int unsigned KCUART_OVERSAMPLE    = 16;
  localparam int unsigned KCUART_TIMEOUT_TICKS =
    KCUART_TMO_CHARS * KCUART_BITS_PER_CHAR * KCUART_OVERSAMPLE;

endpackage

// File: rtl/kcuart_rx_buf_if.sv
// Host/receiver-facing bundle of the RX character buffer.
// slave : used by kcuart_rx_buf (inputs *_i, outputs *_o)
// master: used by the driver (receiver strobe + host register side)
interface kcuart_rx_buf_if #(
  parameter int unsigned ADDR_W = kcuart_pkg::KCUART_RXBUF_ADDR_W
);
  logic              en_16x_baud_i;
  logic [7:0]        data_in_i;
  logic              data_strobe_i;
  logic              rd_en_i;
  logic              clear_i;
  logic [7:0]        data_o;
  logic              empty_o;
  logic              full_o;
  logic              half_full_o;
  logic [ADDR_W:0]   count_o;
  logic              overflow_o;
  logic              timeout_o;

  modport slave (
    input  en_16x_baud_i, data_in_i, data_strobe_i, rd_en_i, clear_i,
    output data_o, empty_o, full_o, half_full_o, count_o, overflow_o, timeout_o
  );

  modport master (
    output en_16x_baud_i, data_in_i, data_strobe_i, rd_en_i, clear_i,
    input  data_o, empty_o, full_o, half_full_o, count_o, overflow_o, timeout_o
  );
endinterface

// File: rtl/kcuart_sync_fifo.sv
// Generic first-word-fall-through synchronous FIFO with sticky overflow.
// Ports: clear_i (sync flush, highest priority), wr_i/wr_data_i (push),
// rd_i (pop head), rd_data_o (registered head, 0 when empty), empty_o,
// full_o, count_o, overflow_o (sticky, write while full without pop),
// count_nxt_c_o / wr_fire_c_o / rd_fire_c_o (combinational, for wrappers).
module kcuart_sync_fifo #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   count_o,
  output logic              overflow_o,
  output logic [ADDR_W:0]   count_nxt_c_o,
  output logic              wr_fire_c_o,
  output logic              rd_fire_c_o
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic              wr_fire, rd_fire;

  // Accept/next-state logic; a pop frees the slot a same-cycle push needs.
  always_comb begin
    rd_fire  = rd_i && !empty_q && !clear_i;
    wr_fire  = wr_i && !clear_i && (!full_q || rd_fire);
    wr_ptr_d = wr_fire ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = rd_fire ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (wr_fire && !rd_fire)      count_d = count_q + CNT_W'(1);
    else if (rd_fire && !wr_fire) count_d = count_q - CNT_W'(1);
    ovf_d = ovf_q || (wr_i && !clear_i && full_q && !rd_fire);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    // Head register: the incoming byte becomes head when it lands at rd_ptr_d.
    if (empty_d)                             head_d = '0;
    else if (wr_fire && rd_ptr_d == wr_ptr_q) head_d = wr_data_i;
    else                                     head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o     = head_q;
  assign empty_o       = empty_q;
  assign full_o        = full_q;
  assign count_o       = count_q;
  assign overflow_o    = ovf_q;
  assign count_nxt_c_o = count_d;
  assign wr_fire_c_o   = wr_fire;
  assign rd_fire_c_o   = rd_fire;
endmodule

// File: rtl/kcuart_rx_buf.sv
// Receive character buffer for the compact UART: 16-deep FWFT FIFO plus
// half-full flag and 16550-style character timeout.
// Ports: clk, rst_n (async active-low), bus (kcuart_rx_buf_if.slave):
// receiver strobe/data, host pop/clear, head data, occupancy flags,
// sticky overflow and timeout.
module kcuart_rx_buf
  import kcuart_pkg::*;
#(
  parameter int unsigned ADDR_W        = KCUART_RXBUF_ADDR_W,
  parameter int unsigned TIMEOUT_TICKS = KCUART_TIMEOUT_TICKS,
  parameter int unsigned TMO_W         = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  kcuart_rx_buf_if.slave bus
);
  localparam int unsigned   DEPTH    = 1 << ADDR_W;
  localparam int unsigned   CNT_W    = ADDR_W + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_TICKS - 1);

  logic [CNT_W-1:0] count, count_nxt;
  logic             empty, wr_fire, rd_fire;
  logic             half_q, half_d, timeout_q, timeout_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  kcuart_sync_fifo #(.ADDR_W(ADDR_W), .DATA_W(8)) u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_i       (bus.clear_i),
    .wr_i          (bus.data_strobe_i),
    .wr_data_i     (bus.data_in_i),
    .rd_i          (bus.rd_en_i),
    .rd_data_o     (bus.data_o),
    .empty_o       (empty),
    .full_o        (bus.full_o),
    .count_o       (count),
    .overflow_o    (bus.overflow_o),
    .count_nxt_c_o (count_nxt),
    .wr_fire_c_o   (wr_fire),
    .rd_fire_c_o   (rd_fire)
  );

  // Character timeout: counts baud ticks while data sits untouched.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_d = timeout_q;
    half_d    = (count_nxt >= CNT_W'(DEPTH / 2));
    if (bus.clear_i || wr_fire || rd_fire) begin
      tmo_cnt_d = '0;
      timeout_d = 1'b0;
    end else if (empty) begin
      tmo_cnt_d = '0;
    end else if (bus.en_16x_baud_i && !timeout_q) begin
      if (tmo_cnt_q == TMO_LAST) timeout_d = 1'b1;
      else                       tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
      half_q    <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      timeout_q <= timeout_d;
      half_q    <= half_d;
    end
  end

  assign bus.empty_o     = empty;
  assign bus.count_o     = count;
  assign bus.half_full_o = half_q;
  assign bus.timeout_o   = timeout_q;
endmodule

// File: tb/tb_kcuart_rx_buf.sv
// Scoreboarded bench for kcuart_rx_buf: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every accepted host read.
module tb_kcuart_rx_buf;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q [$];

  kcuart_rx_buf_if #(.ADDR_W(4)) bus ();

  kcuart_rx_buf #(.ADDR_W(4), .TIMEOUT_TICKS(640), .TMO_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.en_16x_baud_i = 1'b1;
      step();
      bus.en_16x_baud_i = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic wr(input logic [7:0] d, input bit expect_store);
    bus.data_strobe_i = 1'b1;
    bus.data_in_i     = d;
    if (expect_store) exp_q.push_back(d);
    step();
    bus.data_strobe_i = 1'b0;
  endtask

  task automatic rd(input int n);
    bus.rd_en_i = 1'b1;
    repeat (n) step();
    bus.rd_en_i = 1'b0;
  endtask

  // Monitor: every accepted read must present the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && bus.rd_en_i && !bus.empty_o && !bus.clear_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_data: got %0h with no byte expected at %0t", bus.data_o, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (bus.data_o !== e) begin
          errors++;
          $display("FAIL rd_data: got %0h expected %0h at %0t", bus.data_o, e, $time);
        end
      end
    end
  end

  initial begin
    bus.en_16x_baud_i = 1'b0;
    bus.data_in_i     = 8'h00;
    bus.data_strobe_i = 1'b0;
    bus.rd_en_i       = 1'b0;
    bus.clear_i       = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) step();
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_full",  32'(bus.full_o), 0);
    chk("rst_half",  32'(bus.half_full_o), 0);
    chk("rst_ovf",   32'(bus.overflow_o), 0);
    chk("rst_tmo",   32'(bus.timeout_o), 0);
    chk("rst_data",  32'(bus.data_o), 0);
    rst_n = 1'b1;
    step();

    // Single byte in and out; read on empty is ignored.
    wr(8'hA5, 1'b1);
    chk("t1_data",  32'(bus.data_o), 32'hA5);
    chk("t1_count", 32'(bus.count_o), 1);
    chk("t1_empty", 32'(bus.empty_o), 0);
    rd(1);
    chk("t1_empty_after", 32'(bus.empty_o), 1);
    chk("t1_data_after",  32'(bus.data_o), 0);
    rd(1);
    chk("t1_rd_empty_count", 32'(bus.count_o), 0);
    chk("t1_rd_empty_ovf",   32'(bus.overflow_o), 0);

    // Fill, overflow, drain in order.
    for (int i = 0; i < 16; i++) begin
      wr(8'(i), 1'b1);
      chk("t2_count", 32'(bus.count_o), 32'(i + 1));
      chk("t2_half",  32'(bus.half_full_o), (i + 1 >= 8) ? 1 : 0);
      chk("t2_full",  32'(bus.full_o), (i == 15) ? 1 : 0);
    end
    wr(8'hFF, 1'b0);
    chk("t2_ovf",      32'(bus.overflow_o), 1);
    chk("t2_ovf_cnt",  32'(bus.count_o), 16);
    chk("t2_ovf_head", 32'(bus.data_o), 32'h00);
    rd(16);
    chk("t2_drained", 32'(bus.empty_o), 1);
    chk("t2_ovf_sticky", 32'(bus.overflow_o), 1);

    // Full with simultaneous strobe and read.
    bus.clear_i = 1'b1;
    step();
    bus.clear_i = 1'b0;
    chk("t3_clr_ovf", 32'(bus.overflow_o), 0);
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1'b1);
    bus.rd_en_i = 1'b1;
    wr(8'h77, 1'b1);
    bus.rd_en_i = 1'b0;
    chk("t3_count", 32'(bus.count_o), 16);
    chk("t3_ovf",   32'(bus.overflow_o), 0);
    chk("t3_head",  32'(bus.data_o), 32'h11);
    rd(16);
    chk("t3_empty", 32'(bus.empty_o), 1);

    // Empty with simultaneous strobe and read, then wrap-around streaming.
    bus.rd_en_i = 1'b1;
    wr(8'h3C, 1'b1);
    chk("t4_count", 32'(bus.count_o), 1);
    chk("t4_head",  32'(bus.data_o), 32'h3C);
    for (int i = 0; i < 20; i++) wr(8'(8'h80 + i), 1'b1);
    bus.rd_en_i = 1'b0;
    chk("t4_wrap_count", 32'(bus.count_o), 1);
    chk("t4_wrap_head",  32'(bus.data_o), 32'h93);
    rd(1);
    chk("t4_empty", 32'(bus.empty_o), 1);

    // Character timeout.
    wr(8'h11, 1'b1);
    wr(8'h22, 1'b1);
    ticks(639);
    chk("t5_tmo_639", 32'(bus.timeout_o), 0);
    bus.en_16x_baud_i = 1'b1;
    step();
    bus.en_16x_baud_i = 1'b0;
    chk("t5_tmo_640", 32'(bus.timeout_o), 1);
    ticks(5);
    chk("t5_tmo_hold", 32'(bus.timeout_o), 1);
    rd(1);
    chk("t5_tmo_rd_clr", 32'(bus.timeout_o), 0);
    chk("t5_count",      32'(bus.count_o), 1);
    ticks(639);
    chk("t5_tmo_restart_639", 32'(bus.timeout_o), 0);
    bus.en_16x_baud_i = 1'b1;
    step();
    bus.en_16x_baud_i = 1'b0;
    chk("t5_tmo_restart_640", 32'(bus.timeout_o), 1);
    rd(1);
    chk("t5_tmo_clr2", 32'(bus.timeout_o), 0);
    ticks(700);
    chk("t5_tmo_empty", 32'(bus.timeout_o), 0);

    // Clear coincident with a strobe at count 5 and overflow set.
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i), 1'b1);
    wr(8'hFF, 1'b0);
    rd(11);
    chk("t6_pre_count", 32'(bus.count_o), 5);
    chk("t6_pre_ovf",   32'(bus.overflow_o), 1);
    bus.clear_i = 1'b1;
    exp_q.delete();
    wr(8'hEE, 1'b0);
    bus.clear_i = 1'b0;
    chk("t6_count", 32'(bus.count_o), 0);
    chk("t6_empty", 32'(bus.empty_o), 1);
    chk("t6_ovf",   32'(bus.overflow_o), 0);
    chk("t6_data",  32'(bus.data_o), 0);
    wr(8'h5A, 1'b1);
    chk("t6_head", 32'(bus.data_o), 32'h5A);
    rd(1);

    // Asynchronous reset mid-operation.
    wr(8'hC1, 1'b1);
    wr(8'hC2, 1'b1);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    chk("t7_async_count", 32'(bus.count_o), 0);
    chk("t7_async_empty", 32'(bus.empty_o), 1);
    chk("t7_async_data",  32'(bus.data_o), 0);
    step();
    rst_n = 1'b1;
    step();
    wr(8'hD7, 1'b1);
    chk("t7_resume_head", 32'(bus.data_o), 32'hD7);
    rd(1);
    step();

    chk("sb_leftover", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kcuart_rx_buf.md
# kcuart_rx_buf

Receive-side character buffer for the compact UART. It sits directly downstream of the UART receiver and captures each byte the receiver strobes out into a 16-deep first-word-fall-through FIFO. It presents the bytes to the host/register interface with occupancy flags, a sticky overflow flag, and a character-timeout indication (16550-style). The timeout fires when data sits unread while the line stays idle.

## Interface
Parameters:
- `ADDR_W`, 4: FIFO address width; depth = 2**ADDR_W.
- `TIMEOUT_TICKS`, 640: `en_16x_baud_i` ticks without FIFO activity before `timeout_o` (640 = 4 chars × 10 bits × 16).
- `TMO_W`, 16: timeout counter width; `TIMEOUT_TICKS` must be < 2**TMO_W.

Ports:
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en_16x_baud_i` in 1: 16× baud enable, same one fed to the receiver.
- `data_in_i` in 8: received byte from the receiver.
- `data_strobe_i` in 1: one-cycle pulse; `data_in_i` is valid in that cycle.
- `rd_en_i` in 1: host pops the head entry in this cycle.
- `clear_i` in 1: synchronous flush.
- `data_o` out 8: head entry; valid only when `empty_o`=0.
- `empty_o` out 1: FIFO empty.
- `full_o` out 1: count == depth.
- `half_full_o` out 1: count ≥ depth/2.
- `count_o` out ADDR_W+1: current occupancy, 0..depth.
- `overflow_o` out 1: sticky; a byte was dropped because the FIFO was full.
- `timeout_o` out 1: sticky; the character timeout has expired.

## Operation
- Reset values:
  - `count_o`=0, `empty_o`=1.
  - `full_o`, `half_full_o`, `overflow_o`, `timeout_o` = 0.
  - `data_o`=8'h00; read/write pointers = 0.
- Write: accepted when `data_strobe_i`=1 and (not full, or full with an accepted read in the same cycle).
  - Writes `mem[wr_ptr]`; `wr_ptr` wraps modulo depth.
- Read: accepted when `rd_en_i`=1 and not empty.
  - `rd_ptr` advances and wraps modulo depth.
  - `rd_en_i` on empty is ignored: no pointer change, no error flag.
- Count:
  - +1 on an accepted write only; −1 on an accepted read only.
  - Unchanged when both are accepted together.
- Full with strobe and no read: the byte is dropped, `overflow_o` is set, and FIFO contents are unchanged.
- Empty with strobe and read together: the read is ignored and the write is accepted (count becomes 1).
- `clear_i`: pointers, count, `overflow_o` and `timeout_o` go to 0.
  - `clear_i` has priority over a write or read in the same cycle; that byte is discarded.
  - No flag is set for the discarded byte.
- Overflow clears only on reset or `clear_i`.
- `data_o` = `mem[rd_ptr]` (FWFT). Memory contents are not reset; `data_o` is forced to 0 while empty.
- Timeout counter `tmo_cnt`:
  - Reset to 0 on any accepted write, any accepted read, `clear_i`, or while empty.
  - Otherwise increments on `en_16x_baud_i` while `timeout_o`=0.
  - When a tick arrives with `tmo_cnt` == `TIMEOUT_TICKS`−1, `timeout_o` is set and the counter holds.
  - `timeout_o` clears on an accepted write, an accepted read, or `clear_i`.

## Timing
- All state updates on the `posedge clk` of the strobe/read cycle.
- Write latency: flags, `count_o` and `data_o` reflect a write on the cycle after the strobe. Byte-to-`data_o` latency is 1 cycle when the FIFO was empty.
- Read: `data_o` shows the next entry (or 0 if empty) on the cycle after `rd_en_i`.
- Back-to-back reads are allowed on every cycle.
- Strobes arrive at most once per character time, but the block must accept them on consecutive cycles.
- `timeout_o` rises 1 cycle after the qualifying tick.
- Asserting `rst_n` low mid-operation forces the reset values immediately (asynchronously). Operation resumes on the first clock edge after release.

## Structure
- Package `kcuart_pkg`: `KCUART_RXBUF_ADDR_W`=4 and `KCUART_TMO_CHARS`=4. `TIMEOUT_TICKS` derives from these (chars × 10 × 16).
- Sub-module `kcuart_sync_fifo`: generic FWFT FIFO (mem, pointers, count, full/empty, overflow on write-when-full).
- The top level adds `half_full_o`, `clear_i` priority, and the timeout counter. `kcuart_sync_fifo` is reused by the TX-side buffer.

## Test plan
- Reset, then write 8'hA5 → next cycle `data_o`=A5, `count_o`=1, `empty_o`=0; pulse `rd_en_i` → `empty_o`=1, `data_o`=0.
- Write 16 bytes 0x00..0x0F → `half_full_o` rises at count 8, `full_o`=1 at 16. A 17th strobe (0xFF) sets `overflow_o`; reading all 16 returns 0x00..0x0F in order.
- Full FIFO with strobe 0x77 and `rd_en_i` in the same cycle → `count_o` stays 16, `overflow_o` stays 0, 0x77 is read last.
- Empty FIFO with strobe and read together → `count_o`=1, head = written byte; 20 wrap-around write/read cycles return correct data.
- One byte held, `en_16x_baud_i` every 4 clocks → `timeout_o` rises 1 cycle after the 640th tick. A read clears it and the counter resets; with the FIFO empty the flag never asserts.
- `clear_i` coincident with a strobe at count 5 with `overflow_o` set → next cycle count=0, `empty_o`=1, `overflow_o`=0, and the byte is not stored.
